mem_port_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one shared memory/bus port used by four requesters (e.g. fetch, load/store, DMA, debug).
- Drives the 2-bit select of the shared 4:1 word mux that steers the requesters' address/data onto the port.
- Issues a start pulse, waits for the port's ready, and returns a one-cycle done pulse to the winner.
- Supports bounded locked back-to-back transfers and a transaction timeout.

---
 rtl/mem_port_rr_arbiter_pkg.sv | 21 ++
 rtl/mem_port_rr_arbiter_rr_priority_picker.sv | 35 +++
 rtl/mem_port_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_rr_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_rr_arbiter_pkg.sv
// mem_port_rr_arbiter_pkg: shared sizes, FSM state encoding and a one-hot helper.
// Rev 1.0
`default_nettype none

package mem_port_rr_arbiter_pkg;

  localparam int NUM_REQ   = 4;
  localparam int SEL_WIDTH = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_rr_arbiter_rr_priority_picker.sv
// rr_priority_picker: first requester at or after ptr, scanning upward with wrap.
// Rev 1.0
`default_nettype none

module rr_priority_picker
  import mem_port_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic [SEL_WIDTH-1:0] winner_o,
  output logic                 any_req_o
);

  logic [SEL_WIDTH-1:0] w_idx;
  logic                 w_found;

  always_comb begin
    winner_o = ptr_i;
    w_found  = 1'b0;
    w_idx    = ptr_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Index arithmetic wraps naturally at SEL_WIDTH bits.
      w_idx = ptr_i + SEL_WIDTH'(k);
      if (!w_found && req_i[w_idx]) begin
        winner_o = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/mem_port_rr_arbiter.sv
// mem_port_rr_arbiter: round-robin owner selection and start/ready/done sequencing
// for one shared memory port, with bounded locked chaining and a WAIT timeout. Rev 1.0
`default_nettype none

module mem_port_rr_arbiter
  import mem_port_rr_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_LOCK       = 4,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   lock,
  input  logic                 mem_ready,
  output logic [SEL_WIDTH-1:0] select,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 mem_start,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [CNT_WIDTH-1:0] C_TO_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [3:0] C_MAX_LOCK = 4'(MAX_LOCK);

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] select_q, select_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 start_q, start_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           lock_cnt_q, lock_cnt_d;

  logic [SEL_WIDTH-1:0] winner;
  logic                 any_req;

  rr_priority_picker u_picker (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  always_comb begin
    state_d    = state_q;
    select_d   = select_q;
    grant_d    = grant_q;
    start_d    = 1'b0;
    done_d     = '0;
    busy_d     = busy_q;
    err_d      = err_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    lock_cnt_d = lock_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          select_d   = winner;
          grant_d    = onehot(winner);
          start_d    = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = '0;
          lock_cnt_d = 4'd1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          done_d[select_q] = 1'b1;
          if (lock[select_q] && req[select_q] && (lock_cnt_q < C_MAX_LOCK)) begin
            start_d    = 1'b1;
            cnt_d      = '0;
            lock_cnt_d = lock_cnt_q + 4'd1;
          end else begin
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = select_q + SEL_WIDTH'(1);
            state_d = ST_IDLE;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == C_TO_LAST)) begin
          err_d   = 1'b1;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = select_q + SEL_WIDTH'(1);
          state_d = ST_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      select_q   <= '0;
      grant_q    <= '0;
      start_q    <= 1'b0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      select_q   <= select_d;
      grant_q    <= grant_d;
      start_q    <= start_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign select      = select_q;
  assign grant       = grant_q;
  assign mem_start   = start_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_rr_arbiter.sv
// tb_mem_port_rr_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbiter. Rev 1.0
`default_nettype none

module tb_mem_port_rr_arbiter;

  localparam int TO  = 8;
  localparam int MXL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] lock = '0;
  logic       mem_ready = 1'b0;
  logic [1:0] select;
  logic [3:0] grant;
  logic       mem_start;
  logic [3:0] done;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mem_port_rr_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .MAX_LOCK       (MXL),
    .CNT_WIDTH      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .req         (req),
    .lock        (lock),
    .mem_ready   (mem_ready),
    .select      (select),
    .grant       (grant),
    .mem_start   (mem_start),
    .done        (done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Transaction-level model: who owns the port, how long it has waited,
  // how many transfers it has chained, and where the scan starts next.
  bit         m_busy;
  int         m_owner;
  int         m_last;
  int         m_ptr;
  int         m_waited;
  int         m_chain;
  bit         m_err;
  bit         m_start;
  logic [3:0] m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_last = 0; m_ptr = 0;
      m_waited = 0; m_chain = 0; m_err = 0; m_start = 0; m_done = '0;
    end else begin
      m_start = 0;
      m_done  = '0;
      if (!m_busy) begin
        if (req != 0) begin
          for (int k = 3; k >= 0; k--)
            if (req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
          m_last = m_owner; m_busy = 1; m_start = 1; m_waited = 0; m_chain = 1;
        end
      end else if (mem_ready) begin
        m_done[m_owner] = 1'b1;
        if (lock[m_owner] && req[m_owner] && m_chain < MXL) begin
          m_start = 1; m_waited = 0; m_chain++;
        end else begin
          m_busy = 0; m_ptr = (m_owner + 1) % 4;
        end
      end else begin
        m_waited++;
        if (TO != 0 && m_waited == TO) begin
          m_err = 1; m_busy = 0; m_ptr = (m_owner + 1) % 4;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model.select", 32'(select), 32'(m_last));
      chk("model.grant", 32'(grant), m_busy ? (32'd1 << m_owner) : 32'd0);
      chk("model.mem_start", 32'(mem_start), 32'(m_start));
      chk("model.done", 32'(done), 32'(m_done));
      chk("model.busy", 32'(busy), 32'(m_busy));
      chk("model.timeout_err", 32'(timeout_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; lock = '0; mem_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    cmp_en = 1'b1;
    chk("reset.grant", 32'(grant), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.select", 32'(select), 0);

    // Single transfer, owner drops req once granted.
    req = 4'b0001; mem_ready = 1'b1;
    tick();
    chk("t1.grant", 32'(grant), 32'b0001);
    chk("t1.mem_start", 32'(mem_start), 1);
    req = 4'b0000;
    tick();
    chk("t1.done", 32'(done), 32'b0001);
    chk("t1.busy", 32'(busy), 0);
    tick();
    chk("t1.idle_start", 32'(mem_start), 0);
    chk("t1.idle_done_ignored", 32'(done), 0);

    // All request, ready one cycle after each start: 0,1,2,3,0 with a bubble.
    do_reset();
    req = 4'b1111; mem_ready = 1'b0;
    tick();
    for (int n = 0; n < 5; n++) begin
      chk("rr.select", 32'(select), 32'(n % 4));
      chk("rr.start", 32'(mem_start), 1);
      tick();
      mem_ready = 1'b1;
      tick();
      chk("rr.done", 32'(done), 32'd1 << (n % 4));
      mem_ready = 1'b0;
      if (n == 4) req = 4'b0000;
      tick();
    end

    // Locked chaining of requester 2, requester 0 waiting.
    do_reset();
    req = 4'b0100; lock = 4'b0100; mem_ready = 1'b1;
    tick();
    chk("lock.grant", 32'(grant), 32'b0100);
    req = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("lock.done", 32'(done), 32'b0100);
      chk("lock.restart", 32'(mem_start), (n < 3) ? 1 : 0);
    end
    chk("lock.release", 32'(grant), 0);
    tick();
    chk("lock.next_sel", 32'(select), 0);
    req = 4'b0000; lock = 4'b0000;
    tick();
    tick();

    // Timeout on requester 1.
    req = 4'b0010; mem_ready = 1'b0;
    tick();
    chk("to.grant", 32'(grant), 32'b0010);
    req = 4'b0000;
    repeat (TO - 1) tick();
    chk("to.still_waiting", 32'(grant), 32'b0010);
    tick();
    chk("to.abort_grant", 32'(grant), 0);
    chk("to.err", 32'(timeout_err), 1);
    chk("to.no_done", 32'(done), 0);
    req = 4'b0001; mem_ready = 1'b1;
    tick();
    req = 4'b0000;
    tick();
    chk("to.sticky", 32'(timeout_err), 1);

    // Asynchronous reset in the middle of a transfer.
    req = 4'b0010; mem_ready = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.grant", 32'(grant), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.err", 32'(timeout_err), 0);
    tick();
    rst_n = 1'b1;
    req = 4'b0110;
    tick();
    chk("arst.first_sel", 32'(select), 1);
    req = 4'b0000; mem_ready = 1'b1;
    tick();
    tick();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      req       = 4'($urandom);
      lock      = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
      mem_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) req = '0;
      tick();
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
